// File: rtl/rv_pipe_pkg.sv
// Package: rv_pipe_pkg
// Shared encodings for the pipeline hazard controller.
//   FWD_RF / FWD_WB / FWD_MEM : ALU operand mux selects
//   hazard_state_t            : hazard FSM states (RUN, MEM_WAIT)
package rv_pipe_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // operand from WB result
    localparam logic [1:0] FWD_MEM = 2'b10;  // operand from EX_MEM ALU result

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hazard_state_t;

endpackage

// File: rtl/rv_forward_unit.sv
// Module: rv_forward_unit
// Combinational ALU operand forwarding selects for the EX stage.
// Ports:
//   ex_rs1, ex_rs2  in   source registers of the instruction in EX
//   mem_rd          in   destination register in MEM
//   mem_reg_write   in   MEM instruction writes the register file
//   wb_rd           in   destination register in WB
//   wb_reg_write    in   WB instruction writes the register file
//   forward_a/b     out  operand select (FWD_RF / FWD_WB / FWD_MEM)
module rv_forward_unit
    import rv_pipe_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b
);

    logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;

    // x0 is hardwired zero and is never a forwarding source.
    always_comb begin
        mem_hit_a = mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs1);
        mem_hit_b = mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs2);
        wb_hit_a  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == ex_rs1);
        wb_hit_b  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == ex_rs2);
    end

    // The younger EX_MEM result wins over WB when both match.
    always_comb begin
        forward_a = FWD_RF;
        forward_b = FWD_RF;
        if (mem_hit_a)      forward_a = FWD_MEM;
        else if (wb_hit_a)  forward_a = FWD_WB;
        if (mem_hit_b)      forward_b = FWD_MEM;
        else if (wb_hit_b)  forward_b = FWD_WB;
    end

endmodule

// File: rtl/rv_pipeline_hazard_ctrl.sv
// Module: rv_pipeline_hazard_ctrl
// Central hazard controller for the 5-stage RISC-V pipeline: load-use stall,
// taken-branch flush (branch resolved in MEM), multi-cycle data-memory wait,
// operand forwarding and saturating performance counters.
// Ports:
//   clk, reset (sync, active-low)
//   id_rs1/id_rs2, id_use_rs1/id_use_rs2  ID-stage source regs and usage
//   ex_rs1/ex_rs2, ex_rd, ex_mem_read     EX-stage regs, load flag
//   mem_rd, mem_reg_write, mem_access     MEM-stage dest, RF write, ld/st
//   wb_rd, wb_reg_write                   WB-stage dest, RF write
//   branch_taken                          MEM-stage branch resolved taken
//   pc_write, *_write, *_flush, *_bubble  pipeline register controls
//   forward_a/b                           ALU operand selects
//   cnt_loaduse/cnt_memwait/cnt_flush     performance counters
module rv_pipeline_hazard_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MEM_LAT = 0,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic              mem_access,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic              branch_taken,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_write,
    output logic              id_ex_bubble,
    output logic              ex_mem_write,
    output logic              ex_mem_bubble,
    output logic              mem_wb_bubble,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic [CNT_W-1:0]  cnt_loaduse,
    output logic [CNT_W-1:0]  cnt_memwait,
    output logic [CNT_W-1:0]  cnt_flush
);

    localparam int unsigned WCNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);

    hazard_state_t     state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  cnt_loaduse_q, cnt_loaduse_d;
    logic [CNT_W-1:0]  cnt_memwait_q, cnt_memwait_d;
    logic [CNT_W-1:0]  cnt_flush_q, cnt_flush_d;

    logic [1:0] fwd_a_raw, fwd_b_raw;
    logic       load_use;
    logic       mem_start;

    rv_forward_unit #(
        .REG_AW (REG_AW)
    ) u_fwd (
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .forward_a     (fwd_a_raw),
        .forward_b     (fwd_b_raw)
    );

    assign forward_a = reset ? fwd_a_raw : FWD_RF;
    assign forward_b = reset ? fwd_b_raw : FWD_RF;

    always_comb begin
        load_use  = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));
        // done_q marks the access already served, so the same instruction
        // sitting in MEM after its wait does not start a second wait.
        mem_start = (MEM_LAT != 0) && mem_access && !done_q;
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        done_d        = done_q;
        cnt_loaduse_d = cnt_loaduse_q;
        cnt_memwait_d = cnt_memwait_q;
        cnt_flush_d   = cnt_flush_q;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_write  = 1'b1;
        ex_mem_bubble = 1'b0;
        mem_wb_bubble = 1'b0;

        if (!reset) begin
            state_d       = RUN;
            wait_cnt_d    = '0;
            done_d        = 1'b0;
            cnt_loaduse_d = '0;
            cnt_memwait_d = '0;
            cnt_flush_d   = '0;
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_write   = 1'b0;
            id_ex_bubble  = 1'b1;
            ex_mem_write  = 1'b0;
            ex_mem_bubble = 1'b1;
            mem_wb_bubble = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (mem_start) begin
                        pc_write      = 1'b0;
                        if_id_write   = 1'b0;
                        id_ex_write   = 1'b0;
                        ex_mem_write  = 1'b0;
                        mem_wb_bubble = 1'b1;
                        if (cnt_memwait_q != '1) cnt_memwait_d = cnt_memwait_q + 1'b1;
                        // The entry cycle is the first stall cycle; with a
                        // single extra cycle there is nothing left to wait.
                        if (MEM_LAT == 1) begin
                            done_d = 1'b1;
                        end else begin
                            state_d    = MEM_WAIT;
                            wait_cnt_d = WAIT_LOAD;
                        end
                    end else begin
                        // EX_MEM advances in every non-waiting RUN cycle.
                        done_d = 1'b0;
                        if (branch_taken) begin
                            if_id_flush   = 1'b1;
                            id_ex_bubble  = 1'b1;
                            ex_mem_bubble = 1'b1;
                            if (cnt_flush_q != '1) cnt_flush_d = cnt_flush_q + 1'b1;
                        end else if (load_use) begin
                            pc_write     = 1'b0;
                            if_id_write  = 1'b0;
                            id_ex_bubble = 1'b1;
                            if (cnt_loaduse_q != '1) cnt_loaduse_d = cnt_loaduse_q + 1'b1;
                        end
                    end
                end
                MEM_WAIT: begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_write  = 1'b0;
                    mem_wb_bubble = 1'b1;
                    if (cnt_memwait_q != '1) cnt_memwait_d = cnt_memwait_q + 1'b1;
                    // wait_cnt holds the remaining stall cycles including
                    // this one, so total stall is exactly MEM_LAT cycles.
                    if (wait_cnt_q <= WCNT_W'(1)) begin
                        state_d    = RUN;
                        wait_cnt_d = '0;
                        done_d     = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q - 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q       <= state_d;
        wait_cnt_q    <= wait_cnt_d;
        done_q        <= done_d;
        cnt_loaduse_q <= cnt_loaduse_d;
        cnt_memwait_q <= cnt_memwait_d;
        cnt_flush_q   <= cnt_flush_d;
    end

    assign cnt_loaduse = cnt_loaduse_q;
    assign cnt_memwait = cnt_memwait_q;
    assign cnt_flush   = cnt_flush_q;

endmodule

// File: tb/tb_rv_pipeline_hazard_ctrl.sv
module tb_rv_pipeline_hazard_ctrl;

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned MEM_LAT = 3;
    localparam int unsigned CNT_W   = 4;

    // Control bit order: pc_write, if_id_write, if_id_flush, id_ex_write,
    // id_ex_bubble, ex_mem_write, ex_mem_bubble, mem_wb_bubble
    localparam logic [7:0] C_IDLE = 8'b1101_0100;
    localparam logic [7:0] C_RST  = 8'b0010_1011;
    localparam logic [7:0] C_LU   = 8'b0001_1100;
    localparam logic [7:0] C_FL   = 8'b1111_1110;
    localparam logic [7:0] C_MW   = 8'b0000_0001;

    logic              clk;
    logic              reset;
    logic [REG_AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic              id_use_rs1, id_use_rs2, ex_mem_read, mem_reg_write;
    logic              mem_access, wb_reg_write, branch_taken;
    logic              pc_write, if_id_write, if_id_flush, id_ex_write;
    logic              id_ex_bubble, ex_mem_write, ex_mem_bubble, mem_wb_bubble;
    logic [1:0]        forward_a, forward_b;
    logic [CNT_W-1:0]  cnt_loaduse, cnt_memwait, cnt_flush;

    typedef struct {
        string       name;
        logic [7:0]  ctrl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        bit          chk;
        int unsigned lu;
        int unsigned mw;
        int unsigned fl;
    } exp_t;

    exp_t exp_q[$];
    int unsigned n_total  = 0;
    int unsigned n_passed = 0;

    rv_pipeline_hazard_ctrl #(
        .REG_AW  (REG_AW),
        .MEM_LAT (MEM_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .ex_rd         (ex_rd),
        .ex_mem_read   (ex_mem_read),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_access    (mem_access),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .branch_taken  (branch_taken),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .if_id_flush   (if_id_flush),
        .id_ex_write   (id_ex_write),
        .id_ex_bubble  (id_ex_bubble),
        .ex_mem_write  (ex_mem_write),
        .ex_mem_bubble (ex_mem_bubble),
        .mem_wb_bubble (mem_wb_bubble),
        .forward_a     (forward_a),
        .forward_b     (forward_b),
        .cnt_loaduse   (cnt_loaduse),
        .cnt_memwait   (cnt_memwait),
        .cnt_flush     (cnt_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr();
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_mem_read = 1'b0;
        mem_rd = '0; mem_reg_write = 1'b0; mem_access = 1'b0;
        wb_rd = '0; wb_reg_write = 1'b0; branch_taken = 1'b0;
    endtask

    // ld x6 in EX, add x7,x6,x1 in ID
    task automatic set_load_use();
        ex_mem_read = 1'b1; ex_rd = 5'd6;
        id_rs1 = 5'd6; id_use_rs1 = 1'b1;
        id_rs2 = 5'd1; id_use_rs2 = 1'b1;
    endtask

    // Inputs are already applied; queue this cycle's expectation and advance.
    task automatic cyc(input string n, input logic [7:0] c, input logic [1:0] a,
                       input logic [1:0] b, input bit chk, input int unsigned lu,
                       input int unsigned mw, input int unsigned fl);
        exp_t e;
        e.name = n; e.ctrl = c; e.fa = a; e.fb = b;
        e.chk = chk; e.lu = lu; e.mw = mw; e.fl = fl;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_val(input string n, input int unsigned act, input int unsigned req);
        n_total++;
        if (act == req) n_passed++;
        else $display("FAIL %s: got %0d, expected %0d", n, act, req);
    endtask

    // Monitor: every cycle the DUT presents a control word; compare it mid-cycle.
    initial begin
        exp_t e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {pc_write, if_id_write, if_id_flush, id_ex_write,
                       id_ex_bubble, ex_mem_write, ex_mem_bubble, mem_wb_bubble};
                n_total++;
                if (act == e.ctrl) n_passed++;
                else $display("FAIL %s.ctrl: got %b, expected %b", e.name, act, e.ctrl);
                chk_val({e.name, ".fwd_a"}, 32'(forward_a), 32'(e.fa));
                chk_val({e.name, ".fwd_b"}, 32'(forward_b), 32'(e.fb));
                if (e.chk) begin
                    chk_val({e.name, ".cnt_loaduse"}, 32'(cnt_loaduse), e.lu);
                    chk_val({e.name, ".cnt_memwait"}, 32'(cnt_memwait), e.mw);
                    chk_val({e.name, ".cnt_flush"},   32'(cnt_flush),   e.fl);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset: forwarding hit present but suppressed, counters cleared
        ex_rs1 = 5'd5; mem_rd = 5'd5; mem_reg_write = 1'b1;
        cyc("reset", C_RST, 2'b00, 2'b00, 1, 0, 0, 0);

        // 1: forwarding
        reset = 1'b1; clr();
        ex_rs1 = 5'd5; ex_rs2 = 5'd3; mem_rd = 5'd5; mem_reg_write = 1'b1;
        wb_rd = 5'd3; wb_reg_write = 1'b1;
        cyc("fwd_mem_wb", C_IDLE, 2'b10, 2'b01, 1, 0, 0, 0);
        clr();
        ex_rs1 = 5'd5; ex_rs2 = 5'd5; mem_rd = 5'd5; wb_rd = 5'd5; wb_reg_write = 1'b1;
        cyc("fwd_wb_only", C_IDLE, 2'b01, 2'b01, 0, 0, 0, 0);
        clr();
        ex_rs1 = 5'd5; ex_rs2 = 5'd6; mem_rd = 5'd5; mem_reg_write = 1'b1;
        wb_rd = 5'd5; wb_reg_write = 1'b1;
        cyc("fwd_double", C_IDLE, 2'b10, 2'b00, 0, 0, 0, 0);
        clr();
        mem_reg_write = 1'b1; wb_reg_write = 1'b1;
        cyc("fwd_x0", C_IDLE, 2'b00, 2'b00, 0, 0, 0, 0);
        clr();
        ex_rs1 = 5'd5; ex_rs2 = 5'd5; mem_rd = 5'd5; wb_rd = 5'd5;
        cyc("fwd_no_wr", C_IDLE, 2'b00, 2'b00, 0, 0, 0, 0);

        // 2: load-use
        clr(); set_load_use();
        cyc("lu_rs1", C_LU, 2'b00, 2'b00, 1, 0, 0, 0);
        clr();
        cyc("lu_after", C_IDLE, 2'b00, 2'b00, 1, 1, 0, 0);
        clr(); set_load_use(); id_use_rs1 = 1'b0;
        cyc("lu_unused", C_IDLE, 2'b00, 2'b00, 0, 0, 0, 0);
        clr(); ex_mem_read = 1'b1; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        cyc("lu_x0", C_IDLE, 2'b00, 2'b00, 0, 0, 0, 0);
        clr(); set_load_use(); id_rs1 = 5'd2; id_rs2 = 5'd6;
        cyc("lu_rs2", C_LU, 2'b00, 2'b00, 0, 0, 0, 0);
        clr();
        cyc("lu_count2", C_IDLE, 2'b00, 2'b00, 1, 2, 0, 0);

        // 3: flush squashes a simultaneous load-use
        reset = 1'b0;
        cyc("reset2", C_RST, 2'b00, 2'b00, 0, 0, 0, 0);
        reset = 1'b1; clr(); set_load_use(); branch_taken = 1'b1;
        cyc("flush", C_FL, 2'b00, 2'b00, 1, 0, 0, 0);
        clr();
        cyc("flush_after", C_IDLE, 2'b00, 2'b00, 1, 0, 0, 1);

        // 4: store in MEM, MEM_LAT=3; branch ignored while waiting
        clr(); mem_access = 1'b1;
        cyc("mw_enter", C_MW, 2'b00, 2'b00, 1, 0, 0, 1);
        branch_taken = 1'b1;
        cyc("mw_wait1", C_MW, 2'b00, 2'b00, 1, 0, 1, 1);
        branch_taken = 1'b0;
        cyc("mw_wait2", C_MW, 2'b00, 2'b00, 1, 0, 2, 1);
        cyc("mw_no_retrig", C_IDLE, 2'b00, 2'b00, 1, 0, 3, 1);
        mem_access = 1'b0;
        cyc("mw_idle", C_IDLE, 2'b00, 2'b00, 1, 0, 3, 1);

        // 5: new access, reset during second MEM_WAIT cycle
        mem_access = 1'b1;
        cyc("mw2_enter", C_MW, 2'b00, 2'b00, 1, 0, 3, 1);
        cyc("mw2_wait1", C_MW, 2'b00, 2'b00, 1, 0, 4, 1);
        reset = 1'b0;
        cyc("mw2_reset", C_RST, 2'b00, 2'b00, 1, 0, 5, 1);
        reset = 1'b1; mem_access = 1'b0;
        cyc("post_reset_run", C_IDLE, 2'b00, 2'b00, 1, 0, 0, 0);
        mem_access = 1'b1;
        cyc("mw3_enter", C_MW, 2'b00, 2'b00, 1, 0, 0, 0);
        cyc("mw3_wait1", C_MW, 2'b00, 2'b00, 0, 0, 0, 0);
        cyc("mw3_wait2", C_MW, 2'b00, 2'b00, 0, 0, 0, 0);
        mem_access = 1'b0;
        cyc("mw3_done", C_IDLE, 2'b00, 2'b00, 1, 0, 3, 0);

        // 6: counter saturation at CNT_W=4
        reset = 1'b0;
        cyc("reset3", C_RST, 2'b00, 2'b00, 0, 0, 0, 0);
        reset = 1'b1; clr(); set_load_use();
        for (int i = 0; i < 20; i++) begin
            cyc("sat_lu", C_LU, 2'b00, 2'b00, 1, (i > 15) ? 15 : i, 0, 0);
        end
        clr();
        cyc("sat_hold", C_IDLE, 2'b00, 2'b00, 1, 15, 0, 0);

        @(posedge clk);
        #1;
        n_total++;
        if (exp_q.size() == 0) n_passed++;
        else $display("FAIL drain: got %0d pending, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
